wptr_full_ctrl: RTL and testbench
=================================

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ASIZE, default 4, meaning address width; FIFO depth is 2**ASIZE.
REQ-002 SHALL have parameter AF_LEVEL, default 12, meaning almost-full threshold in words; legal range 1..2**ASIZE.
REQ-003 SHALL have port wclk  input  1  write clock; the only clock.
REQ-004 SHALL have port wrst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port winc  input  1  write request.
REQ-006 SHALL have port rptr  input  ASIZE+1  Gray read pointer from the read domain; asynchronous to wclk.
REQ-007 SHALL have port wovf_clr  input  1  clears sticky overflow.
REQ-008 SHALL have port waddr  output  ASIZE  binary RAM write address.
REQ-009 SHALL have port wptr  output  ASIZE+1  registered Gray write pointer, sent to the read domain.
REQ-010 SHALL have port wfull  output  1  FIFO full, registered.
REQ-011 SHALL have port walmost_full  output  1  level >= AF_LEVEL, registered.
REQ-012 SHALL have port wlevel  output  ASIZE+1  occupancy as seen from the write side, registered.
REQ-013 SHALL have port woverflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-014 SHALL synchronise rptr through two wclk flops (rq1, then rq2); only rq2 is used by logic.
REQ-015 SHALL keep a binary counter wbin of ASIZE+1 bits; wbnext = wbin + (winc AND NOT wfull), modulo 2**(ASIZE+1).
REQ-016 SHALL compute wgnext = (wbnext >> 1) XOR wbnext; each edge: wbin <= wbnext, wptr <= wgnext.
REQ-017 SHALL drive waddr = wbin[ASIZE-1:0].
REQ-018 SHALL register wfull <= (wgnext == {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]}).
REQ-019 SHALL convert rq2 from Gray to binary (rbin_s), register wlevel <= wbnext - rbin_s modulo 2**(ASIZE+1), and register walmost_full <= (wbnext - rbin_s) >= AF_LEVEL.
REQ-020 SHALL assert wfull on the same edge that accepts the write filling the last entry (zero-latency full).
REQ-021 SHALL deassert wfull/walmost_full, and lower wlevel, no earlier than 2 edges after a read-pointer change: a value stable before edge N is reflected in the flags after edge N+2.
REQ-022 SHALL ignore winc while wfull=1: wbin, wptr and waddr hold, and woverflow <= 1 on that edge.
REQ-023 SHALL clear woverflow on an edge with wovf_clr=1; if a new overflow and wovf_clr coincide, set wins.
REQ-024 SHALL wrap wbin from 2**(ASIZE+1)-1 to 0 with no discontinuity in the full or level calculations.

Reset
REQ-025 SHALL, on any edge with wrst=1, set rq1, rq2, wbin, wptr, waddr, wlevel to 0 and wfull, walmost_full, woverflow to 0; reset overrides winc and wovf_clr.
REQ-026 SHALL treat reset asserted mid-operation identically; pointers restart from 0, and the read side is reset by its own domain.

Structure
REQ-027 SHALL place the ASIZE default, the bin-to-Gray function and the Gray-to-binary function in the shared FIFO package used by the read-side pointer logic.
REQ-028 SHALL instantiate one sub-module, sync_2ff (parameterised width, wclk, wrst), for the rptr synchroniser; all other logic is inline.

Verification (ASIZE=4, AF_LEVEL=12)
REQ-029 SHALL cover fill: rptr=0, winc=1 for 16 edges -> walmost_full=1 after the 12th edge; wfull=1, wlevel=16 and wptr=5'b11000 after the 16th.
REQ-030 SHALL cover overflow: when full, winc=1 for one edge -> wptr holds 5'b11000, woverflow=1; then wovf_clr=1 -> woverflow=0; wovf_clr=1 coincident with a full write -> woverflow stays 1.
REQ-031 SHALL cover release: when full, rptr changes to 5'b00001 before edge N -> wfull=0 and wlevel=15 after edge N+2, and both unchanged after edges N and N+1.
REQ-032 SHALL cover wrap: 40 writes with rptr tracking wptr two cycles behind -> wbin wraps 31->0, waddr sequence 0..15 repeats, no spurious wfull.
REQ-033 SHALL cover reset mid-fill: after 7 writes, wrst=1 for one edge -> all outputs 0 on that edge, and the next write gives waddr=1 (0 was written on that write).
REQ-034 SHALL cover a simultaneous write and read release at the full boundary: write accepted only when wfull=0 as registered, never on stale release.

Source files
------------

// File: rtl/wptr_full_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wptr_full_ctrl_pkg
//  Description : Shared FIFO package. Holds the default address width and the
//                binary/Gray conversion helpers used by both pointer domains.
//                The helpers work on 32-bit vectors. Callers zero-extend their
//                pointer into the function and size-cast the result back.
//  Revision    : 1.0  initial release
// ============================================================================
package wptr_full_ctrl_pkg;

    localparam int c_ASIZE_DEFAULT = 4;

    // Zero upper bits do not disturb the conversion.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down. Zero upper bits contribute nothing.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 1; i < 32; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage : wptr_full_ctrl_pkg
`default_nettype wire

// File: rtl/wptr_full_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for a multi-bit Gray-coded bus.
//  Ports       : wclk  - destination clock
//                wrst  - synchronous active-high reset
//                d     - asynchronous input bus
//                q     - output from the second synchroniser stage
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= d;
            r_q2 <= r_q1;
        end
    end

    assign q = r_q2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wptr_full_ctrl
//  Description : Write-side pointer and flag logic of an asynchronous FIFO.
//                It keeps the binary and Gray write pointers. It produces
//                zero-latency full, almost-full, occupancy and a sticky
//                overflow flag, all against a synchronised read pointer.
//  Ports       : wclk          - write clock
//                wrst          - synchronous active-high reset
//                winc          - write request
//                rptr          - Gray read pointer (read clock domain)
//                wovf_clr      - clear sticky overflow
//                waddr         - binary RAM write address
//                wptr          - registered Gray write pointer
//                wfull         - FIFO full
//                walmost_full  - level >= AF_LEVEL
//                wlevel        - occupancy seen from the write side
//                woverflow     - sticky: write attempted while full
//  Revision    : 1.0  initial release
// ============================================================================
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int ASIZE    = c_ASIZE_DEFAULT,
    parameter int AF_LEVEL = 12
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [ASIZE:0]   rptr,
    input  logic             wovf_clr,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);

    // Threshold is one bit wider so that AF_LEVEL == 2**ASIZE is representable.
    localparam logic [ASIZE+1:0] c_AF_LEVEL = (ASIZE+2)'(AF_LEVEL);

    logic [ASIZE:0] r_wbin;
    logic [ASIZE:0] r_wptr;
    logic           r_wfull;
    logic           r_walmost_full;
    logic [ASIZE:0] r_wlevel;
    logic           r_woverflow;

    logic [ASIZE:0] w_rq2;
    logic [ASIZE:0] w_wbnext;
    logic [ASIZE:0] w_wgnext;
    logic [ASIZE:0] w_rbin_s;
    logic [ASIZE:0] w_level_next;
    logic           w_full_next;

    sync_2ff #(
        .WIDTH (ASIZE + 1)
    ) u_rptr_sync (
        .wclk (wclk),
        .wrst (wrst),
        .d    (rptr),
        .q    (w_rq2)
    );

    // A write is accepted only against the registered full flag. A read
    // release is therefore never acted on before it reaches wfull.
    assign w_wbnext = r_wbin + (ASIZE+1)'(winc & ~r_wfull);
    assign w_wgnext = (ASIZE+1)'(bin2gray(32'(w_wbnext)));
    assign w_rbin_s = (ASIZE+1)'(gray2bin(32'(w_rq2)));

    // Modulo 2**(ASIZE+1) subtraction stays correct across the pointer wrap.
    assign w_level_next = w_wbnext - w_rbin_s;

    // Full when the next write pointer has gone exactly one lap past the read
    // pointer. In Gray code this means the top two bits are inverted.
    assign w_full_next = (w_wgnext == {~w_rq2[ASIZE:ASIZE-1], w_rq2[ASIZE-2:0]});

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbnext;
            r_wptr         <= w_wgnext;
            r_wfull        <= w_full_next;
            r_walmost_full <= ({1'b0, w_level_next} >= c_AF_LEVEL);
            r_wlevel       <= w_level_next;
            // A new overflow takes priority over a coincident clear.
            if (winc && r_wfull) begin
                r_woverflow <= 1'b1;
            end else if (wovf_clr) begin
                r_woverflow <= 1'b0;
            end
        end
    end

    assign waddr        = r_wbin[ASIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign woverflow    = r_woverflow;

endmodule : wptr_full_ctrl
`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wptr_full_ctrl
//  Description : Self-checking bench for wptr_full_ctrl with ASIZE=4 and
//                AF_LEVEL=12. Uses a directed vector table plus hand-written
//                wrap and mid-fill reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wptr_full_ctrl;

    logic       wclk;
    logic       wrst;
    logic       winc;
    logic [4:0] rptr;
    logic       wovf_clr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    int n_total;
    int n_pass;

    typedef struct {
        logic       rst;
        logic       inc;
        logic       clr;
        logic [4:0] rp;
        logic [3:0] e_waddr;
        logic [4:0] e_wptr;
        logic       e_full;
        logic       e_af;
        logic [4:0] e_lvl;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    wptr_full_ctrl #(
        .ASIZE    (4),
        .AF_LEVEL (12)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .rptr         (rptr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic add(input logic rst, input logic inc, input logic clr, input logic [4:0] rp,
                       input logic [3:0] a, input logic [4:0] p, input logic f,
                       input logic af, input logic [4:0] l, input logic o);
        vec_t v;
        v.rst = rst; v.inc = inc; v.clr = clr; v.rp = rp;
        v.e_waddr = a; v.e_wptr = p; v.e_full = f; v.e_af = af; v.e_lvl = l; v.e_ovf = o;
        vecs.push_back(v);
    endtask

    task automatic step(input logic rst, input logic inc, input logic clr, input logic [4:0] rp);
        wrst = rst; winc = inc; wovf_clr = clr; rptr = rp;
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] a, input logic [4:0] p, input logic f,
                           input logic af, input logic [4:0] l, input logic o);
        chk({tag, ".waddr"}, int'(waddr), int'(a));
        chk({tag, ".wptr"}, int'(wptr), int'(p));
        chk({tag, ".wfull"}, int'(wfull), int'(f));
        chk({tag, ".walmost_full"}, int'(walmost_full), int'(af));
        chk({tag, ".wlevel"}, int'(wlevel), int'(l));
        chk({tag, ".woverflow"}, int'(woverflow), int'(o));
    endtask

    function automatic logic [4:0] g5(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    initial begin
        int cnt;
        n_total = 0;
        n_pass  = 0;
        wrst = 1'b1; winc = 1'b0; wovf_clr = 1'b0; rptr = 5'd0;

        //   rst  inc  clr  rptr       waddr wptr      full af  lvl    ovf
        add(1'b1, 1'b1, 1'b1, 5'b00000, 4'd0, 5'b00000, 1'b0, 1'b0, 5'd0, 1'b0); // reset beats winc
        add(1'b1, 1'b0, 1'b0, 5'b00000, 4'd0, 5'b00000, 1'b0, 1'b0, 5'd0, 1'b0); // flush sync
        // fill 16 with rptr = 0
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd1,  5'b00001, 1'b0, 1'b0, 5'd1,  1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd2,  5'b00011, 1'b0, 1'b0, 5'd2,  1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd3,  5'b00010, 1'b0, 1'b0, 5'd3,  1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd4,  5'b00110, 1'b0, 1'b0, 5'd4,  1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd5,  5'b00111, 1'b0, 1'b0, 5'd5,  1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd6,  5'b00101, 1'b0, 1'b0, 5'd6,  1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd7,  5'b00100, 1'b0, 1'b0, 5'd7,  1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd8,  5'b01100, 1'b0, 1'b0, 5'd8,  1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd9,  5'b01101, 1'b0, 1'b0, 5'd9,  1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd10, 5'b01111, 1'b0, 1'b0, 5'd10, 1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd11, 5'b01110, 1'b0, 1'b0, 5'd11, 1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd12, 5'b01010, 1'b0, 1'b1, 5'd12, 1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd13, 5'b01011, 1'b0, 1'b1, 5'd13, 1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd14, 5'b01001, 1'b0, 1'b1, 5'd14, 1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd15, 5'b01000, 1'b0, 1'b1, 5'd15, 1'b0);
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd0,  5'b11000, 1'b1, 1'b1, 5'd16, 1'b0);
        // overflow, clear, coincident overflow + clear
        add(1'b0, 1'b1, 1'b0, 5'b00000, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1);
        add(1'b0, 1'b0, 1'b1, 5'b00000, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0);
        add(1'b0, 1'b1, 1'b1, 5'b00000, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1);
        // release: rptr -> 1 before edge N. Flags follow after N+2.
        add(1'b0, 1'b0, 1'b1, 5'b00001, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0);
        add(1'b0, 1'b0, 1'b0, 5'b00001, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0);
        add(1'b0, 1'b0, 1'b0, 5'b00001, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b0);
        // refill the freed slot: zero-latency full again
        add(1'b0, 1'b1, 1'b0, 5'b00001, 4'd1, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b0);
        // write held high while read releases one more: stale release is not used
        add(1'b0, 1'b1, 1'b0, 5'b00011, 4'd1, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b1);
        add(1'b0, 1'b1, 1'b0, 5'b00011, 4'd1, 5'b11001, 1'b1, 1'b1, 5'd16, 1'b1);
        add(1'b0, 1'b1, 1'b0, 5'b00011, 4'd1, 5'b11001, 1'b0, 1'b1, 5'd15, 1'b1);
        add(1'b0, 1'b1, 1'b0, 5'b00011, 4'd2, 5'b11011, 1'b1, 1'b1, 5'd16, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].inc, vecs[i].clr, vecs[i].rp);
            chk_all($sformatf("vec%0d", i), vecs[i].e_waddr, vecs[i].e_wptr, vecs[i].e_full,
                    vecs[i].e_af, vecs[i].e_lvl, vecs[i].e_ovf);
        end

        // Wrap: 40 writes with rptr trailing the write count by two.
        step(1'b1, 1'b0, 1'b0, 5'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b0, (cnt >= 2) ? g5(cnt - 2) : 5'd0);
            cnt++;
            chk($sformatf("wrap%0d.waddr", i), int'(waddr), cnt % 16);
            chk($sformatf("wrap%0d.wptr", i), int'(wptr), int'(g5(cnt % 32)));
            chk($sformatf("wrap%0d.wfull", i), int'(wfull), 0);
        end

        // Reset mid-fill: 7 writes, then reset with winc still high.
        step(1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 5'd0);
        chk("midfill.waddr7", int'(waddr), 7);
        step(1'b1, 1'b1, 1'b1, 5'd0);
        chk_all("midrst", 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 5'd0);
        chk_all("postrst", 4'd1, 5'b00001, 1'b0, 1'b0, 5'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wptr_full_ctrl
`default_nettype wire
